// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM state and direction encodings plus default screen geometry.
// Pure declarations, no timing.
// Used by both the paddle controller and ball_engine so geometry stays consistent.
package pong_pkg;

  // Default screen and paddle geometry, in cells
  localparam int DEF_SCR_W    = 30;
  localparam int DEF_SCR_H    = 20;
  localparam int DEF_PADDLE_H = 6;

  // Datapath widths on the renderer / paddle side
  localparam int COORD_W = 11;
  localparam int SCORE_W = 4;

  // Ball engine game state
  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    MOVE   = 2'd1,
    SCORED = 2'd2,
    OVER   = 2'd3
  } state_t;

  // One-bit direction: POS moves toward larger column/row
  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  // Reverse a direction
  function automatic dir_t flip_dir(input dir_t d);
    return (d == DIR_POS) ? DIR_NEG : DIR_POS;
  endfunction

endpackage

// File: rtl/ball_engine_step_timer.sv
// Step timer: divides CLK down to a one-cycle step strobe every TICK_DIV enabled cycles.
// step is combinational from the count; first strobe TICK_DIV cycles after clear releases.
// No backpressure; clr holds the count at zero, en gates counting.
module step_timer
  #(parameter int TICK_DIV = 750000)
  (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic step
  );

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles, wrapping to zero on the step edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == CNT_LAST) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign step = en && !clr && (count == CNT_LAST);

endmodule

// File: rtl/ball_engine.sv
// Ball motion and scoring: steps the ball once per tick, bounces off walls/paddles, keeps scores.
// Outputs registered; ball updates on the step edge, POINT pulses one cycle after a miss edge.
// No backpressure; paddle rows are sampled combinationally on the step edge. Option: WIN_LIMIT_EN.
module ball_engine
  import pong_pkg::*;
  #(
    parameter int SCR_W     = DEF_SCR_W,
    parameter int SCR_H     = DEF_SCR_H,
    parameter int PADDLE_H  = DEF_PADDLE_H,
    parameter int TICK_DIV  = 750000,
    parameter int MAX_SCORE = 9
  )
  (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [10:0] L_PADDLE_POSITION,
    input  logic [10:0] R_PADDLE_POSITION,
    output logic [10:0] BALL_X,
    output logic [10:0] BALL_Y,
    output logic [3:0]  L_SCORE,
    output logic [3:0]  R_SCORE,
    output logic        POINT_L,
    output logic        POINT_R,
    output logic        GAME_OVER
  );

  // Geometry derived from the screen size
  localparam logic [10:0] X_CTR      = 11'(SCR_W / 2);
  localparam logic [10:0] Y_CTR      = 11'(SCR_H / 2);
  localparam logic [10:0] Y_TOP      = 11'd1;
  localparam logic [10:0] Y_BOT      = 11'(SCR_H - 2);
  localparam logic [10:0] X_L_EDGE   = 11'd2;
  localparam logic [10:0] X_R_EDGE   = 11'(SCR_W - 3);
  localparam logic [10:0] X_L_BOUNCE = 11'd3;
  localparam logic [10:0] X_R_BOUNCE = 11'(SCR_W - 4);
  localparam logic [11:0] PAD_SPAN   = 12'(PADDLE_H - 1);

  state_t      state, state_nxt;
  logic [10:0] ball_x, ball_y;
  dir_t        dx, dy;
  logic [3:0]  l_score, r_score;
  logic        point_l, point_r;

  logic        timer_en, timer_clr, step;
  logic        game_over;

  // Step evaluation terms
  logic [10:0] ny;
  dir_t        dy_nxt;
  logic        at_left, at_right, at_edge;
  logic [10:0] pad_row;
  logic [11:0] pad_lo, pad_hi, ny_ext;
  logic        hit, miss;

  step_timer #(.TICK_DIV(TICK_DIV)) u_step_timer (
    .CLK  (CLK),
    .RST  (RST),
    .en   (timer_en),
    .clr  (timer_clr),
    .step (step)
  );

  // Candidate next position: vertical wall bounce, then paddle test on the facing column
  always_comb begin
    dy_nxt = dy;
    ny     = ball_y;
    if (dy == DIR_POS) begin
      if (ball_y >= Y_BOT) begin
        dy_nxt = DIR_NEG;
        ny     = ball_y - 11'd1;
      end else begin
        ny     = ball_y + 11'd1;
      end
    end else begin
      if (ball_y <= Y_TOP) begin
        dy_nxt = DIR_POS;
        ny     = ball_y + 11'd1;
      end else begin
        ny     = ball_y - 11'd1;
      end
    end

    at_left  = (ball_x == X_L_EDGE) && (dx == DIR_NEG);
    at_right = (ball_x == X_R_EDGE) && (dx == DIR_POS);
    at_edge  = at_left || at_right;
    pad_row  = at_left ? L_PADDLE_POSITION : R_PADDLE_POSITION;

    // 12-bit compare so a paddle parked near the top of the range cannot wrap
    ny_ext   = {1'b0, ny};
    pad_lo   = {1'b0, pad_row};
    pad_hi   = {1'b0, pad_row} + PAD_SPAN;
    hit      = (ny_ext >= pad_lo) && (ny_ext <= pad_hi);
    miss     = step && at_edge && !hit;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= SERVE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      SERVE: begin
        if (START) begin
          state_nxt = MOVE;
        end
      end
      MOVE: begin
        if (miss) begin
          state_nxt = SCORED;
        end
      end
      SCORED: begin
`ifdef WIN_LIMIT_EN
        // Scores were bumped on the miss edge, so they already reflect this point
        if ((l_score == 4'(MAX_SCORE)) || (r_score == 4'(MAX_SCORE))) begin
          state_nxt = OVER;
        end else begin
          state_nxt = SERVE;
        end
`else
        state_nxt = SERVE;
`endif
      end
      OVER: begin
`ifdef WIN_LIMIT_EN
        if (START) begin
          state_nxt = SERVE;
        end
`else
        state_nxt = SERVE;
`endif
      end
      default: state_nxt = SERVE;
    endcase
  end

  // Output decode from the state register: timer control and game-over flag
  always_comb begin
    timer_en  = (state == MOVE);
    timer_clr = (state != MOVE);
`ifdef WIN_LIMIT_EN
    game_over = (state == OVER);
`else
    game_over = 1'b0;
`endif
  end

  // Ball position, direction, scores and point pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      ball_x  <= X_CTR;
      ball_y  <= Y_CTR;
      dx      <= DIR_POS;
      dy      <= DIR_POS;
      l_score <= 4'd0;
      r_score <= 4'd0;
      point_l <= 1'b0;
      point_r <= 1'b0;
    end else begin
      point_l <= 1'b0;
      point_r <= 1'b0;
      case (state)
        MOVE: begin
          if (step) begin
            if (at_edge && !hit) begin
              // Ball holds where it was; the player opposite the gap scores
              if (at_right) begin
                l_score <= l_score + 4'd1;
                point_l <= 1'b1;
              end else begin
                r_score <= r_score + 4'd1;
                point_r <= 1'b1;
              end
            end else if (at_edge) begin
              dx     <= flip_dir(dx);
              ball_x <= at_left ? X_L_BOUNCE : X_R_BOUNCE;
              ball_y <= ny;
              dy     <= dy_nxt;
            end else begin
              ball_x <= (dx == DIR_POS) ? (ball_x + 11'd1) : (ball_x - 11'd1);
              ball_y <= ny;
              dy     <= dy_nxt;
            end
          end
        end
        SCORED: begin
          // Recentre and serve toward whoever conceded
          ball_x <= X_CTR;
          ball_y <= Y_CTR;
          dy     <= DIR_POS;
          dx     <= point_l ? DIR_POS : DIR_NEG;
        end
        OVER: begin
`ifdef WIN_LIMIT_EN
          if (START) begin
            l_score <= 4'd0;
            r_score <= 4'd0;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign BALL_X    = ball_x;
  assign BALL_Y    = ball_y;
  assign L_SCORE   = l_score;
  assign R_SCORE   = r_score;
  assign POINT_L   = point_l;
  assign POINT_R   = point_r;
  assign GAME_OVER = game_over;

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: game-rule reference model feeds an event scoreboard.
// Every output change is popped against the next predicted event and its cycle.
// Random paddle rows per point; directed checks for serve, wall bounce and a miss.
module tb_ball_engine;

  localparam int SCR_W      = 30;
  localparam int SCR_H      = 20;
  localparam int PADDLE_H   = 6;
  localparam int TICK_DIV   = 4;
`ifdef WIN_LIMIT_EN
  localparam int MAX_SC     = 2;
  localparam bit WIN        = 1'b1;
`else
  localparam int MAX_SC     = 9;
  localparam bit WIN        = 1'b0;
`endif
  localparam int STEP_LIMIT = 60;   // after this many steps both paddles are moved out of reach
  localparam int FAR_ROW    = 20;   // paddle row that can never be hit
  localparam int CX         = SCR_W / 2;
  localparam int CY         = SCR_H / 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [10:0] L_PADDLE_POSITION;
  logic [10:0] R_PADDLE_POSITION;
  logic [10:0] BALL_X;
  logic [10:0] BALL_Y;
  logic [3:0]  L_SCORE;
  logic [3:0]  R_SCORE;
  logic        POINT_L;
  logic        POINT_R;
  logic        GAME_OVER;

  ball_engine #(
    .SCR_W    (SCR_W),
    .SCR_H    (SCR_H),
    .PADDLE_H (PADDLE_H),
    .TICK_DIV (TICK_DIV),
    .MAX_SCORE(MAX_SC)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .START            (START),
    .L_PADDLE_POSITION(L_PADDLE_POSITION),
    .R_PADDLE_POSITION(R_PADDLE_POSITION),
    .BALL_X           (BALL_X),
    .BALL_Y           (BALL_Y),
    .L_SCORE          (L_SCORE),
    .R_SCORE          (R_SCORE),
    .POINT_L          (POINT_L),
    .POINT_R          (POINT_R),
    .GAME_OVER        (GAME_OVER)
  );

  always #5 CLK = ~CLK;

  // Number of rising edges seen so far
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [32:0] v;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // Reference game state
  int mx = CX, my = CY, mdx = 1, mdy = 1, mls = 0, mrs = 0;
  bit mover = 1'b0;

  function automatic logic [32:0] pack(input int x, input int y, input int ls, input int rs,
                                       input int pl, input int pr, input int go);
    return {11'(x), 11'(y), 4'(ls), 4'(rs), 1'(pl), 1'(pr), 1'(go)};
  endfunction

  function automatic void push(input int x, input int y, input int ls, input int rs,
                               input int pl, input int pr, input int go, input int c);
    exp_t e;
    e.v   = pack(x, y, ls, rs, pl, pr, go);
    e.cyc = c;
    q.push_back(e);
  endfunction

  // Predict one point from the edge t0 that enters MOVE; returns the recentre edge
  function automatic int play_point(input int lp, input int rp, input int t0);
    for (int k = 1; k < 1000; k++) begin
      int ec, lpk, rpk, ny, p;
      ec  = t0 + TICK_DIV * k;
      lpk = (k > STEP_LIMIT) ? FAR_ROW : lp;
      rpk = (k > STEP_LIMIT) ? FAR_ROW : rp;
      ny  = my + mdy;
      if (ny < 1 || ny > SCR_H - 2) begin
        mdy = -mdy;
        ny  = my + mdy;
      end
      if ((mx == 2 && mdx < 0) || (mx == SCR_W - 3 && mdx > 0)) begin
        p = (mdx < 0) ? lpk : rpk;
        if (ny >= p && ny <= p + PADDLE_H - 1) begin
          mdx = -mdx;
          mx  = mx + mdx;
          my  = ny;
          push(mx, my, mls, mrs, 0, 0, 0, ec);
        end else begin
          if (mdx > 0) mls = (mls + 1) % 16;
          else         mrs = (mrs + 1) % 16;
          push(mx, my, mls, mrs, int'(mdx > 0), int'(mdx < 0), 0, ec);
          mover = WIN && (mls == MAX_SC || mrs == MAX_SC);
          // Next serve heads toward the side that conceded, i.e. mdx is kept
          mx  = CX;
          my  = CY;
          mdy = 1;
          push(mx, my, mls, mrs, 0, 0, int'(mover), ec + 1);
          return ec + 1;
        end
      end else begin
        mx = mx + mdx;
        my = ny;
        push(mx, my, mls, mrs, 0, 0, 0, ec);
      end
    end
    return t0;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every change of the output bundle must match the next predicted event
  logic        mon_en   = 1'b0;
  bit          mon_init = 1'b0;
  logic [32:0] last;
  always @(negedge CLK) begin
    logic [32:0] cur;
    exp_t        e;
    if (mon_en) begin
      cur = {BALL_X, BALL_Y, L_SCORE, R_SCORE, POINT_L, POINT_R, GAME_OVER};
      if (!mon_init) begin
        last     = cur;
        mon_init = 1'b1;
      end else if (cur !== last) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got=%h (x=%0d y=%0d) cyc %0d", cur, cur[32:22], cur[21:11], cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.v) begin
            failures++;
            $display("FAIL event_value got=%h exp=%h (got x=%0d y=%0d, exp x=%0d y=%0d) cyc %0d",
                     cur, e.v, cur[32:22], cur[21:11], e.v[32:22], e.v[21:11], cyc);
          end
          checks++;
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL event_time got cyc=%0d exp cyc=%0d", cyc, e.cyc);
          end
        end
        last = cur;
      end
    end
  end

  // Play one point; optional directed spot checks for a serve into a right-side miss
  task automatic run_point(input int lp, input int rp, input bit directed);
    int t0, tend, swap;
    if (mover) begin
      // OVER: START only returns to SERVE and clears the scores
      @(negedge CLK);
      START = 1'b1;
      mls = 0; mrs = 0; mover = 1'b0;
      push(CX, CY, 0, 0, 0, 0, 0, cyc + 1);
      @(negedge CLK);
      START = 1'b0;
      repeat (3) @(negedge CLK);
    end
    @(negedge CLK);
    L_PADDLE_POSITION = 11'(lp);
    R_PADDLE_POSITION = 11'(rp);
    START = 1'b1;
    t0   = cyc + 1;
    tend = play_point(lp, rp, t0);
    swap = t0 + TICK_DIV * STEP_LIMIT;
    @(negedge CLK);
    START = 1'b0;
    while (cyc < tend + 3) begin
      @(negedge CLK);
      if (cyc == swap) begin
        L_PADDLE_POSITION = 11'(FAR_ROW);
        R_PADDLE_POSITION = 11'(FAR_ROW);
      end
      if (directed) begin
        if (cyc == t0 + TICK_DIV - 1) check("no_step_early_x", int'(BALL_X), CX);
        if (cyc == t0 + TICK_DIV) begin
          check("step1_x", int'(BALL_X), 16);
          check("step1_y", int'(BALL_Y), 11);
        end
        if (cyc == t0 + 8 * TICK_DIV) begin
          check("step8_x", int'(BALL_X), 23);
          check("step8_y", int'(BALL_Y), 18);
        end
        if (cyc == t0 + 9 * TICK_DIV) begin
          check("bounce_x", int'(BALL_X), 24);
          check("bounce_y", int'(BALL_Y), 17);
        end
        if (cyc == t0 + 13 * TICK_DIV) begin
          check("miss_point_l", int'(POINT_L), 1);
          check("miss_point_r", int'(POINT_R), 0);
          check("miss_hold_x", int'(BALL_X), 27);
        end
        if (cyc == t0 + 13 * TICK_DIV + 1) begin
          check("recentre_point_l", int'(POINT_L), 0);
          check("recentre_x", int'(BALL_X), CX);
          check("recentre_y", int'(BALL_Y), CY);
        end
      end
    end
  endtask

  initial begin
    int lp, rp;
    RST = 1'b1;
    START = 1'b0;
    L_PADDLE_POSITION = 11'd0;
    R_PADDLE_POSITION = 11'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("reset_ball_x", int'(BALL_X), CX);
    check("reset_ball_y", int'(BALL_Y), CY);
    check("reset_l_score", int'(L_SCORE), 0);
    check("reset_r_score", int'(R_SCORE), 0);
    check("reset_points", int'({POINT_L, POINT_R}), 0);
    check("reset_game_over", int'(GAME_OVER), 0);
    mon_en = 1'b1;
    // Idle in SERVE: the monitor flags any movement
    repeat (20) @(negedge CLK);

    // Serve into a right-side miss (free flight, wall bounce, left scores)
    run_point(5, 1, 1'b1);
    check("first_miss_l_score", int'(L_SCORE), 1);
    // Same trajectory again: second left point (ends the game with the win limit)
    run_point(5, 1, 1'b0);
    check("game_over_flag", int'(GAME_OVER), int'(WIN));
    // Right paddle returns the ball at step 13, left paddle misses later
    run_point(0, 10, 1'b0);
    // Paddles near the top of the 11-bit range must never register a hit
    run_point(2047, 2045, 1'b0);

    for (int i = 0; i < 10; i++) begin
      lp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2040, 2047)) : int'($urandom_range(0, 16));
      rp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2040, 2047)) : int'($urandom_range(0, 16));
      run_point(lp, rp, 1'b0);
    end

    repeat (10) @(negedge CLK);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ball_engine.md
# ball_engine

Ball motion and scoring stage placed directly downstream of the paddle controller. It consumes the left and right paddle row positions, advances the ball one cell per step tick, and reflects the ball off the top and bottom walls and off the paddles. It detects misses, keeps both scores and drives the ball coordinates to the renderer.

## Interface

Parameters:
- SCR_W, 30, screen width in cells
- SCR_H, 20, screen height in cells
- PADDLE_H, 6, paddle height in rows
- TICK_DIV, 750000, clock cycles per ball step (≥2)
- MAX_SCORE, 9, winning score (used only with WIN_LIMIT_EN)

Ports:
- CLK  in  1  system clock, 75 MHz
- RST  in  1  reset, synchronous, active-high
- START  in  1  level; serves the ball / restarts after game over
- L_PADDLE_POSITION  in  11  top row of the left paddle
- R_PADDLE_POSITION  in  11  top row of the right paddle
- BALL_X  out  11  ball column
- BALL_Y  out  11  ball row
- L_SCORE  out  4  left player score
- R_SCORE  out  4  right player score
- POINT_L  out  1  one-cycle pulse when left scores
- POINT_R  out  1  one-cycle pulse when right scores
- GAME_OVER  out  1  high in OVER state

One clock; reset is synchronous and active-high.

## Operation

- Geometry:
  - Playable rows are 1..SCR_H-2.
  - Left paddle column is 1; right paddle column is SCR_W-2.
  - Ball columns in play are 2..SCR_W-3.
  - Centre is (SCR_W/2, SCR_H/2).
- Direction: dx, dy ∈ {+1, -1}, each held as 1 bit.
- States:
  - SERVE: ball held at centre. START=1 moves to MOVE.
  - MOVE: a step fires each tick.
  - SCORED: lasts one cycle, recentres the ball, then goes to SERVE (or OVER).
  - OVER: see Configuration.
- Step evaluation:
  1. ny = y+dy. If ny would leave 1..SCR_H-2, flip dy and set ny = y+new dy.
  2. Horizontal: if x=2 and dx=-1, or x=SCR_W-3 and dx=+1, test the facing paddle.
     - Hit when pos ≤ ny ≤ pos+PADDLE_H-1. Evaluate in 12 bits so the sum cannot overflow.
     - Hit: flip dx, x moves one cell away from the paddle, y=ny.
     - Miss: the opposite player's score increments, the matching POINT pulse fires, and the state goes to SCORED. BALL_X/Y hold.
  3. Otherwise x=x+dx, y=ny.
- Paddle positions are sampled combinationally at the step edge. They are not registered.
- SCORED → SERVE:
  - Ball goes to centre.
  - dx points toward the player who conceded.
  - dy=+1.
- Reset values:
  - State SERVE; ball at centre; dx=+1, dy=+1.
  - Scores 0; POINT_L=POINT_R=0; GAME_OVER=0; tick counter 0.
- RST mid-play overrides everything on the next edge.

## Timing

- Tick counter runs only in MOVE. It clears on entry to MOVE.
- A step fires when count = TICK_DIV-1, and the counter wraps to 0 on that edge.
- The first step occurs TICK_DIV cycles after the edge that enters MOVE.
- All outputs are registered and update on the step edge.
- POINT_L/R are high for exactly the cycle after the miss edge, which coincides with SCORED.
- START held high continuously re-serves on the cycle after SERVE is entered.

## Configuration

- WIN_LIMIT_EN defined:
  - The miss edge that brings a score to MAX_SCORE leads SCORED → OVER.
  - In OVER, GAME_OVER=1 and the ball sits at centre.
  - START=1 clears both scores and goes to SERVE.
- WIN_LIMIT_EN undefined:
  - OVER is unreachable and GAME_OVER is tied to 0.
  - Scores wrap 15→0.

## Structure

- Shared package pong_pkg holds:
  - state encoding (SERVE, MOVE, SCORED, OVER)
  - direction encoding
  - default SCR_W/SCR_H/PADDLE_H constants, shared with the paddle controller
- Sub-module step_timer holds the TICK_DIV counter, with enable and clear inputs and a one-cycle step output.

## Test plan

Settings for all tests: SCR_W=30, SCR_H=20, PADDLE_H=6, TICK_DIV=4.

- Reset: assert RST for 2 cycles → BALL=(15,10), scores 0/0, POINT_L=POINT_R=0, GAME_OVER=0, state SERVE. Ball does not move while START=0.
- Step timing: START pulse → first move to (16,11) exactly 4 cycles after entering MOVE, then one step every 4 cycles.
- Wall bounce: free flight from serve → at step 8 ball is (23,18); at step 9 it is (24,17) with dy=-1.
- Paddle hit: R_PADDLE_POSITION=10 → step 12 gives (27,14), step 13 gives (26,13) with dx=-1. Scores unchanged.
- Miss: R_PADDLE_POSITION=1 → step 13 gives L_SCORE=1, POINT_L=1 for one cycle, POINT_R=0. Next cycle ball is at (15,10) in SERVE with dx=+1.
- Win limit (WIN_LIMIT_EN, MAX_SCORE=2): two right misses → GAME_OVER=1 and START is ignored for serve. Then START=1 → scores 0/0, GAME_OVER=0, state SERVE.
